// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 distributor.
package demux_pkg;

  localparam int unsigned NR_CH   = 4;
  localparam int unsigned SEL_LEN = 2;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned cnt_len(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO with occupancy count; no bypass, head shown on rdata (0 when empty).
module demux_fifo
  import demux_pkg::*;
#(
  parameter  int unsigned DATA_LEN = 2,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned CNT_LEN  = cnt_len(DEPTH),
  localparam int unsigned PTR_LEN  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic [CNT_LEN-1:0]  cnt
);

  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [DATA_LEN-1:0] mem_d [DEPTH];
  logic [PTR_LEN-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_LEN-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_LEN-1:0]  cnt_q, cnt_d;
  logic                push_ok, pop_ok;

  assign full    = (cnt_q == CNT_LEN'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign cnt     = cnt_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state: write at tail, advance pointers (power-of-2 depth wraps naturally), track count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = PTR_LEN'(wr_ptr_q + 1'b1);
    end
    if (pop_ok) begin
      rd_ptr_d = PTR_LEN'(rd_ptr_q + 1'b1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = CNT_LEN'(cnt_q + 1'b1);
      2'b01:   cnt_d = CNT_LEN'(cnt_q - 1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset clears storage too so nothing stale can ever resurface.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/demux14_dist.sv
// 1-to-4 distributor: routes each input beat to the FIFO of the channel named by in_sel.
module demux14_dist
  import demux_pkg::*;
#(
  parameter  int unsigned DATA_LEN = 2,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned CNT_LEN  = cnt_len(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_LEN-1:0]        in_sel,
  input  logic [DATA_LEN-1:0]       in_data,
  output logic [NR_CH-1:0]          out_valid,
  input  logic [NR_CH-1:0]          out_ready,
  output logic [NR_CH*DATA_LEN-1:0] out_data,
  output logic [NR_CH*CNT_LEN-1:0]  out_cnt
);

  logic [NR_CH-1:0]    push_vec;
  logic [NR_CH-1:0]    full_vec;
  logic [NR_CH-1:0]    empty_vec;
  logic [DATA_LEN-1:0] rdata_arr [NR_CH];
  logic [CNT_LEN-1:0]  cnt_arr   [NR_CH];

  // One-hot push decode of the destination channel.
  always_comb begin
    push_vec = '0;
    for (int unsigned k = 0; k < NR_CH; k++) begin
      push_vec[k] = in_valid && (in_sel == SEL_LEN'(k));
    end
  end

  // Ready depends only on the selected channel's fullness; forced high while in reset.
  assign in_ready = rst | ~full_vec[in_sel];

  for (genvar g = 0; g < int'(NR_CH); g++) begin : g_ch
    demux_fifo #(
      .DATA_LEN (DATA_LEN),
      .DEPTH    (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[g]),
      .pop   (out_ready[g]),
      .wdata (in_data),
      .rdata (rdata_arr[g]),
      .full  (full_vec[g]),
      .empty (empty_vec[g]),
      .cnt   (cnt_arr[g])
    );

    // Outputs read as idle while reset is asserted, before the synchronous clear lands.
    assign out_valid[g]                       = ~rst & ~empty_vec[g];
    assign out_data[g*DATA_LEN +: DATA_LEN]   = rst ? '0 : rdata_arr[g];
    assign out_cnt[g*CNT_LEN +: CNT_LEN]      = rst ? '0 : cnt_arr[g];
  end

endmodule

// File: tb/tb_demux14_dist.sv
// Bench for demux14_dist: hand-computed vector table plus a per-channel scoreboard.
module tb_demux14_dist;

  logic clk = 1'b0;
  logic rst;

  // Index 0: DEPTH=2 instance, index 1: DEPTH=4 instance (random soak).
  logic [1:0]       in_valid_p;
  logic [1:0]       in_ready_p;
  logic [1:0][1:0]  in_sel_p;
  logic [1:0][1:0]  in_data_p;
  logic [1:0][3:0]  out_valid_p;
  logic [1:0][3:0]  out_ready_p;
  logic [1:0][7:0]  out_data_p;
  logic [7:0]       out_cnt0;
  logic [11:0]      out_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux14_dist #(.DATA_LEN(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_p[0]), .in_ready(in_ready_p[0]),
    .in_sel(in_sel_p[0]), .in_data(in_data_p[0]),
    .out_valid(out_valid_p[0]), .out_ready(out_ready_p[0]),
    .out_data(out_data_p[0]), .out_cnt(out_cnt0)
  );

  demux14_dist #(.DATA_LEN(2), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_p[1]), .in_ready(in_ready_p[1]),
    .in_sel(in_sel_p[1]), .in_data(in_data_p[1]),
    .out_valid(out_valid_p[1]), .out_ready(out_ready_p[1]),
    .out_data(out_data_p[1]), .out_cnt(out_cnt1)
  );

  // Scoreboard: expected beats in arrival order, tagged with instance and channel.
  typedef struct {
    int         inst;
    int         ch;
    logic [1:0] d;
  } ent_t;
  ent_t sb[$];

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [1:0] d;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov;
  } vec_t;
  vec_t tab [22];

  function automatic int mcnt(input int inst, input int ch);
    int n = 0;
    foreach (sb[i]) if (sb[i].inst == inst && sb[i].ch == ch) n++;
    return n;
  endfunction

  function automatic logic [1:0] mhead(input int inst, input int ch);
    foreach (sb[i]) if (sb[i].inst == inst && sb[i].ch == ch) return sb[i].d;
    return 2'd0;
  endfunction

  function automatic void mpop(input int inst, input int ch);
    int idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].inst == inst && sb[i].ch == ch) idx = i;
    if (idx >= 0) sb.delete(idx);
  endfunction

  function automatic logic [31:0] act_cnt(input int inst, input int k);
    if (inst == 0) return 32'(out_cnt0[k*2 +: 2]);
    return 32'(out_cnt1[k*3 +: 3]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle on one instance: drive, check against the model before the edge, update model at the edge.
  task automatic step(input int inst, input logic v, input logic [1:0] sel, input logic [1:0] d,
                      input logic [3:0] ordy, input string tag,
                      input logic use_tab, input logic t_rdy, input logic [3:0] t_ov);
    int         dep;
    logic       exp_rdy;
    logic       pushm;
    logic [3:0] popm;
    dep              = (inst == 0) ? 2 : 4;
    in_valid_p       = '0;
    out_ready_p      = '0;
    in_valid_p[inst] = v;
    in_sel_p[inst]   = sel;
    in_data_p[inst]  = d;
    out_ready_p[inst] = ordy;
    #1;
    exp_rdy = (mcnt(inst, int'(sel)) < dep);
    chk({tag, ".in_ready"}, 32'(in_ready_p[inst]), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), 32'(out_valid_p[inst][k]), 32'(mcnt(inst, k) != 0));
      chk($sformatf("%s.data%0d", tag, k), 32'(out_data_p[inst][k*2 +: 2]), 32'(mhead(inst, k)));
      chk($sformatf("%s.cnt%0d", tag, k), act_cnt(inst, k), 32'(mcnt(inst, k)));
      popm[k] = ordy[k] && (mcnt(inst, k) != 0);
    end
    if (use_tab) begin
      chk({tag, ".tab_ready"}, 32'(in_ready_p[inst]), 32'(t_rdy));
      chk({tag, ".tab_valid"}, 32'(out_valid_p[inst]), 32'(t_ov));
    end
    pushm = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (popm[k]) mpop(inst, k);
    if (pushm) sb.push_back('{inst, int'(sel), d});
    #1;
  endtask

  // Synchronous reset for one cycle, with an optional push presented to instance 0 during it.
  task automatic do_reset(input logic v0, input logic [1:0] sel0, input logic [1:0] d0);
    rst            = 1'b1;
    in_valid_p     = '0;
    out_ready_p    = '0;
    in_valid_p[0]  = v0;
    in_sel_p[0]    = sel0;
    in_data_p[0]   = d0;
    #1;
    chk("rst_active.in_ready0", 32'(in_ready_p[0]), 32'd1);
    chk("rst_active.valid0", 32'(out_valid_p[0]), 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    in_valid_p = '0;
    sb.delete();
    chk("post_rst.in_ready0", 32'(in_ready_p[0]), 32'd1);
    chk("post_rst.in_ready1", 32'(in_ready_p[1]), 32'd1);
    chk("post_rst.valid0", 32'(out_valid_p[0]), 32'd0);
    chk("post_rst.valid1", 32'(out_valid_p[1]), 32'd0);
    chk("post_rst.cnt0", 32'(out_cnt0), 32'd0);
    chk("post_rst.cnt1", 32'(out_cnt1), 32'd0);
    chk("post_rst.data0", 32'(out_data_p[0]), 32'd0);
    chk("post_rst.data1", 32'(out_data_p[1]), 32'd0);
  endtask

  initial begin
    logic       sv, rej;
    logic [1:0] ssel, sd;
    logic [3:0] sr;

    // Routing, all consumers ready.
    tab[0]  = '{1'b1, 2'd0, 2'd1, 4'hF, 1'b1, 4'b0000};
    tab[1]  = '{1'b1, 2'd1, 2'd2, 4'hF, 1'b1, 4'b0001};
    tab[2]  = '{1'b1, 2'd2, 2'd3, 4'hF, 1'b1, 4'b0010};
    tab[3]  = '{1'b1, 2'd3, 2'd0, 4'hF, 1'b1, 4'b0100};
    tab[4]  = '{1'b0, 2'd0, 2'd0, 4'hF, 1'b1, 4'b1000};
    // Backpressure on ch1, ch3 still flows, held third beat accepted after first pop.
    tab[5]  = '{1'b1, 2'd1, 2'd1, 4'b1101, 1'b1, 4'b0000};
    tab[6]  = '{1'b1, 2'd1, 2'd2, 4'b1101, 1'b1, 4'b0010};
    tab[7]  = '{1'b1, 2'd1, 2'd3, 4'b1101, 1'b0, 4'b0010};
    tab[8]  = '{1'b1, 2'd3, 2'd2, 4'b1101, 1'b1, 4'b0010};
    tab[9]  = '{1'b1, 2'd1, 2'd3, 4'hF,    1'b0, 4'b1010};
    tab[10] = '{1'b1, 2'd1, 2'd3, 4'hF,    1'b1, 4'b0010};
    tab[11] = '{1'b0, 2'd0, 2'd0, 4'hF,    1'b1, 4'b0010};
    // Full ch0 with simultaneous pop: push rejected that cycle, accepted the next.
    tab[12] = '{1'b1, 2'd0, 2'd1, 4'b0000, 1'b1, 4'b0000};
    tab[13] = '{1'b1, 2'd0, 2'd2, 4'b0000, 1'b1, 4'b0001};
    tab[14] = '{1'b1, 2'd0, 2'd3, 4'b0001, 1'b0, 4'b0001};
    tab[15] = '{1'b1, 2'd0, 2'd3, 4'b0000, 1'b1, 4'b0001};
    tab[16] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b0, 4'b0001};
    tab[17] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b1, 4'b0001};
    // Same-cycle push and pop on ch2 at cnt=1; then ready on empty channels does nothing.
    tab[18] = '{1'b1, 2'd2, 2'd1, 4'b0000, 1'b1, 4'b0000};
    tab[19] = '{1'b1, 2'd2, 2'd2, 4'b0100, 1'b1, 4'b0100};
    tab[20] = '{1'b0, 2'd2, 2'd0, 4'b0100, 1'b1, 4'b0100};
    tab[21] = '{1'b0, 2'd0, 2'd0, 4'hF,    1'b1, 4'b0000};

    rst         = 1'b1;
    in_valid_p  = '0;
    in_sel_p    = '0;
    in_data_p   = '0;
    out_ready_p = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 2'd0, 2'd0);

    // Reset with beats stored in ch2 and a push in flight.
    step(0, 1'b1, 2'd2, 2'd1, 4'h0, "fill0", 1'b1, 1'b1, 4'b0000);
    step(0, 1'b1, 2'd2, 2'd2, 4'h0, "fill1", 1'b1, 1'b1, 4'b0100);
    chk("fill.cnt2", act_cnt(0, 2), 32'd2);
    do_reset(1'b1, 2'd1, 2'd3);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 2'd2, 2'd0, 4'hF, "after_rst", 1'b1, 1'b1, 4'b0000);

    for (int i = 0; i < 22; i++)
      step(0, tab[i].v, tab[i].sel, tab[i].d, tab[i].ordy, $sformatf("vec%0d", i),
           1'b1, tab[i].rdy, tab[i].ov);

    // Random soak on the DEPTH=4 instance; producer holds a rejected beat stable.
    sv = 1'b0; ssel = 2'd0; sd = 2'd0; rej = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!rej) begin
        sv   = ($urandom_range(0, 99) < 60);
        ssel = 2'($urandom_range(0, 3));
        sd   = 2'($urandom_range(0, 3));
      end
      for (int k = 0; k < 4; k++) sr[k] = ($urandom_range(0, 99) < 35);
      rej = sv && (mcnt(1, int'(ssel)) >= 4);
      step(1, sv, ssel, sd, sr, "soak", 1'b0, 1'b0, 4'b0000);
    end
    // Drain and confirm nothing is left over or duplicated.
    for (int i = 0; i < 6; i++) step(1, 1'b0, 2'd0, 2'd0, 4'hF, "drain", 1'b0, 1'b0, 4'b0000);
    chk("drain.cnt1_all", 32'(out_cnt1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
